// File: rtl/credit_pkg.sv
// Shared widths and transaction/parking-entry types for the credit retry source.
package credit_pkg;

    localparam int ID_W = 3;
    localparam int PL_W = 5;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [PL_W-1:0] payload;
    } txn_t;

    typedef struct packed {
        txn_t txn;
        logic granted;
    } park_entry_t;

endpackage

// File: rtl/credit_park_buf.sv
// Arrival-ordered compacting parking queue with grant matching and pop-oldest-granted.
// Per-entry watchdog ages are built only when CREDIT_WDOG_EN is defined.
module credit_park_buf
    import credit_pkg::*;
#(
    parameter int NUM_RETRY   = 4,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             push_i,
    input  txn_t                             push_txn_i,
    input  logic                             grant_i,
    input  logic [ID_W-1:0]                  grant_id_i,
    input  logic                             pop_i,
    output logic                             has_granted_o,
    output txn_t                             head_txn_o,
    output logic                             grant_err_o,
    output logic [$clog2(NUM_RETRY+1)-1:0]   count_o,
    output logic                             wdog_o
);

    localparam int CW = $clog2(NUM_RETRY + 1);

    park_entry_t   ent_q  [NUM_RETRY];
    park_entry_t   ent_d  [NUM_RETRY];
    park_entry_t   marked [NUM_RETRY];
    logic [CW-1:0] cnt_q, cnt_d;
    int unsigned   pop_idx, gnt_idx, tail;
    logic          gnt_hit, push_gnt;

    always_comb begin
        has_granted_o = 1'b0;
        pop_idx       = 0;
        gnt_hit       = 1'b0;
        gnt_idx       = 0;
        for (int unsigned i = 0; i < NUM_RETRY; i++) begin
            if (i < 32'(cnt_q)) begin
                if (!has_granted_o && ent_q[i].granted) begin
                    has_granted_o = 1'b1;
                    pop_idx       = i;
                end
                if (!gnt_hit && !ent_q[i].granted && ent_q[i].txn.id == grant_id_i) begin
                    gnt_hit = 1'b1;
                    gnt_idx = i;
                end
            end
        end
        head_txn_o = ent_q[pop_idx].txn;

        // Grant is resolved on the pre-pop array, falling back to the entry parked this cycle.
        marked = ent_q;
        if (grant_i && gnt_hit)
            marked[gnt_idx].granted = 1'b1;
        push_gnt    = grant_i && !gnt_hit && push_i && (push_txn_i.id == grant_id_i);
        grant_err_o = grant_i && !gnt_hit && !push_gnt;

        for (int unsigned i = 0; i < NUM_RETRY; i++)
            ent_d[i] = (pop_i && i >= pop_idx) ? marked[(i + 1 < NUM_RETRY) ? i + 1 : i] : marked[i];
        tail = 32'(cnt_q) - 32'(pop_i);
        if (push_i && tail < NUM_RETRY)
            ent_d[tail] = '{txn: push_txn_i, granted: push_gnt};
        cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            for (int unsigned i = 0; i < NUM_RETRY; i++)
                ent_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
            ent_q <= ent_d;
        end
    end

    assign count_o = cnt_q;

`ifdef CREDIT_WDOG_EN
    localparam int AW = $clog2(WDOG_CYCLES + 1);

    logic [AW-1:0] age_q [NUM_RETRY];
    logic [AW-1:0] age_d [NUM_RETRY];
    logic          wdog_q, wdog_hit;

    always_comb begin
        wdog_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_RETRY; i++) begin
            age_d[i] = (pop_i && i >= pop_idx) ? age_q[(i + 1 < NUM_RETRY) ? i + 1 : i] : age_q[i];
            if (i < tail && !ent_d[i].granted && 32'(age_d[i]) < WDOG_CYCLES)
                age_d[i] = age_d[i] + AW'(1);
            if (push_i && i == tail)
                age_d[i] = '0;
            if (i < 32'(cnt_d) && 32'(age_d[i]) >= WDOG_CYCLES)
                wdog_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_RETRY; i++)
                age_q[i] <= '0;
        end else begin
            age_q <= age_d;
            if (wdog_hit)
                wdog_q <= 1'b1;
        end
    end

    assign wdog_o = wdog_q;
`else
    // Never true for a legal limit; keeps the limit referenced when no ages are built.
    assign wdog_o = (WDOG_CYCLES < 0);
`endif

endmodule

// File: rtl/credit_retry_source.sv
// Upstream issuing agent: output stage, replay-first load priority and producer back-pressure.
// Watchdog flag is live only when CREDIT_WDOG_EN is defined (see credit_park_buf).
module credit_retry_source
    import credit_pkg::*;
#(
    parameter int ID_W        = credit_pkg::ID_W,
    parameter int PL_W        = credit_pkg::PL_W,
    parameter int NUM_RETRY   = 4,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid_i,
    input  logic [ID_W-1:0]                  in_id_i,
    input  logic [PL_W-1:0]                  in_payload_i,
    output logic                             in_ready_o,
    output logic                             rx_valid_o,
    output logic [ID_W-1:0]                  rx_id_o,
    output logic [PL_W-1:0]                  rx_payload_o,
    output logic                             rx_credit_o,
    input  logic                             rx_ready_i,
    input  logic                             rx_retry_i,
    input  logic                             credit_gnt_i,
    input  logic [ID_W-1:0]                  credit_id_i,
    output logic [$clog2(NUM_RETRY+1)-1:0]   park_cnt_o,
    output logic                             err_o,
    output logic                             wdog_o
);

    logic out_valid_q, out_credit_q, err_q;
    txn_t out_txn_q, head_txn, in_txn;
    logic done, retry, free, pop, has_granted, grant_err;

    assign done   = out_valid_q & (rx_ready_i | rx_retry_i);
    assign retry  = out_valid_q & rx_retry_i & ~rx_ready_i;
    assign free   = ~out_valid_q | done;
    assign pop    = free & has_granted;
    assign in_txn = '{id: in_id_i, payload: in_payload_i};

    // One slot stays reserved so the accepted transaction can always park on retry.
    assign in_ready_o = ~reset & free & ~has_granted &
                        (32'(park_cnt_o) + 32'(retry) - 32'(pop) + 1 <= NUM_RETRY);

    credit_park_buf #(
        .NUM_RETRY   (NUM_RETRY),
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_park_buf (
        .clk           (clk),
        .reset         (reset),
        .push_i        (retry),
        .push_txn_i    (out_txn_q),
        .grant_i       (credit_gnt_i),
        .grant_id_i    (credit_id_i),
        .pop_i         (pop),
        .has_granted_o (has_granted),
        .head_txn_o    (head_txn),
        .grant_err_o   (grant_err),
        .count_o       (park_cnt_o),
        .wdog_o        (wdog_o)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_txn_q    <= '0;
            out_credit_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if (pop) begin
                out_valid_q  <= 1'b1;
                out_txn_q    <= head_txn;
                out_credit_q <= 1'b1;
            end else if (in_valid_i && in_ready_o) begin
                out_valid_q  <= 1'b1;
                out_txn_q    <= in_txn;
                out_credit_q <= 1'b0;
            end else if (done) begin
                out_valid_q <= 1'b0;
            end
            if (grant_err || (retry && out_credit_q))
                err_q <= 1'b1;
        end
    end

    assign rx_valid_o   = out_valid_q;
    assign rx_id_o      = out_txn_q.id;
    assign rx_payload_o = out_txn_q.payload;
    assign rx_credit_o  = out_credit_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_credit_retry_source.sv
// Directed self-checking bench for credit_retry_source (NUM_RETRY=4, WDOG_CYCLES=8).
module tb_credit_retry_source;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid_i = 1'b0;
    logic [2:0] in_id_i = '0;
    logic [4:0] in_payload_i = '0;
    logic       in_ready_o;
    logic       rx_valid_o;
    logic [2:0] rx_id_o;
    logic [4:0] rx_payload_o;
    logic       rx_credit_o;
    logic       rx_ready_i = 1'b0;
    logic       rx_retry_i = 1'b0;
    logic       credit_gnt_i = 1'b0;
    logic [2:0] credit_id_i = '0;
    logic [2:0] park_cnt_o;
    logic       err_o;
    logic       wdog_o;

    int errors = 0;
    int checks = 0;
    logic wdog_exp;

    credit_retry_source #(
        .ID_W        (3),
        .PL_W        (5),
        .NUM_RETRY   (4),
        .WDOG_CYCLES (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid_i   (in_valid_i),
        .in_id_i      (in_id_i),
        .in_payload_i (in_payload_i),
        .in_ready_o   (in_ready_o),
        .rx_valid_o   (rx_valid_o),
        .rx_id_o      (rx_id_o),
        .rx_payload_o (rx_payload_o),
        .rx_credit_o  (rx_credit_o),
        .rx_ready_i   (rx_ready_i),
        .rx_retry_i   (rx_retry_i),
        .credit_gnt_i (credit_gnt_i),
        .credit_id_i  (credit_id_i),
        .park_cnt_o   (park_cnt_o),
        .err_o        (err_o),
        .wdog_o       (wdog_o)
    );

    always #5 clk = ~clk;

`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin errors++; $error("FAIL %s: got %0h expected %0h", tag, obs, exp); end end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            assert (park_cnt_o <= 3'd4) else begin
                errors++;
                $error("FAIL park_cnt_bound: got %0d expected <= 4", park_cnt_o);
            end
        end
    end

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        `CHK("rst_rx_valid", rx_valid_o, 1'b0)
        `CHK("rst_park_cnt", park_cnt_o, 3'd0)
        `CHK("rst_err", err_o, 1'b0)
        `CHK("rst_wdog", wdog_o, 1'b0)
        `CHK("rst_in_ready", in_ready_o, 1'b0)
        reset = 1'b0;
        #1;
        `CHK("post_rst_in_ready", in_ready_o, 1'b1)

        // plain pass-through, one cycle latency
        in_valid_i = 1'b1; in_id_i = 3'd2; in_payload_i = 5'h11; rx_ready_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        `CHK("pass_valid", rx_valid_o, 1'b1)
        `CHK("pass_id", rx_id_o, 3'd2)
        `CHK("pass_payload", rx_payload_o, 5'h11)
        `CHK("pass_credit", rx_credit_o, 1'b0)
        `CHK("pass_park_cnt", park_cnt_o, 3'd0)
        tick();
        `CHK("pass_drained", rx_valid_o, 1'b0)

        // retry parks, grant replays with credit
        rx_ready_i = 1'b0;
        in_valid_i = 1'b1; in_id_i = 3'd3; in_payload_i = 5'h03;
        tick();
        in_valid_i = 1'b0; rx_retry_i = 1'b1;
        tick();
        rx_retry_i = 1'b0;
        `CHK("park1_cnt", park_cnt_o, 3'd1)
        `CHK("park1_valid", rx_valid_o, 1'b0)
        credit_gnt_i = 1'b1; credit_id_i = 3'd3;
        tick();
        credit_gnt_i = 1'b0;
        #1;
        `CHK("gnt_pending_ready", in_ready_o, 1'b0)
        tick();
        `CHK("replay3_valid", rx_valid_o, 1'b1)
        `CHK("replay3_id", rx_id_o, 3'd3)
        `CHK("replay3_credit", rx_credit_o, 1'b1)
        `CHK("replay3_cnt", park_cnt_o, 3'd0)
        rx_ready_i = 1'b1;
        tick();
        `CHK("replay3_done", rx_valid_o, 1'b0)

        // park ids 1,5,1; grant id 1 replays the oldest before new producer data
        rx_ready_i = 1'b0; rx_retry_i = 1'b1;
        in_valid_i = 1'b1; in_id_i = 3'd1; in_payload_i = 5'h01;
        tick();
        in_id_i = 3'd5; in_payload_i = 5'h05;
        tick();
        in_id_i = 3'd1; in_payload_i = 5'h0A;
        tick();
        in_valid_i = 1'b0;
        tick();
        rx_retry_i = 1'b0;
        `CHK("park3_cnt", park_cnt_o, 3'd3)
        credit_gnt_i = 1'b1; credit_id_i = 3'd1;
        tick();
        credit_gnt_i = 1'b0;
        in_valid_i = 1'b1; in_id_i = 3'd7; in_payload_i = 5'h07;
        #1;
        `CHK("order_ready_blocked", in_ready_o, 1'b0)
        tick();
        `CHK("order_id", rx_id_o, 3'd1)
        `CHK("order_payload_oldest", rx_payload_o, 5'h01)
        `CHK("order_credit", rx_credit_o, 1'b1)
        `CHK("order_cnt", park_cnt_o, 3'd2)
        rx_ready_i = 1'b1;
        #1;
        `CHK("order_ready_after", in_ready_o, 1'b1)
        tick();
        in_valid_i = 1'b0;
        `CHK("new_id", rx_id_o, 3'd7)
        `CHK("new_credit", rx_credit_o, 1'b0)
        tick();
        rx_ready_i = 1'b0;
        `CHK("second_id1_parked", park_cnt_o, 3'd2)

        // capacity back-pressure: 3 parked plus one in the output stage
        in_valid_i = 1'b1; in_id_i = 3'd2; in_payload_i = 5'h12;
        tick();
        in_valid_i = 1'b0; rx_retry_i = 1'b1;
        tick();
        rx_retry_i = 1'b0;
        in_valid_i = 1'b1; in_id_i = 3'd4; in_payload_i = 5'h14;
        #1;
        `CHK("cap_ready_3parked", in_ready_o, 1'b1)
        tick();
        in_id_i = 3'd0; in_payload_i = 5'h1F;
        #1;
        `CHK("cap_ready_busy", in_ready_o, 1'b0)
        rx_retry_i = 1'b1;
        #1;
        `CHK("cap_ready_retry", in_ready_o, 1'b0)
        tick();
        rx_retry_i = 1'b0;
        #1;
        `CHK("cap_full_cnt", park_cnt_o, 3'd4)
        `CHK("cap_full_ready", in_ready_o, 1'b0)
        credit_gnt_i = 1'b1; credit_id_i = 3'd5;
        tick();
        credit_gnt_i = 1'b0;
        tick();
        `CHK("cap_replay_id", rx_id_o, 3'd5)
        `CHK("cap_replay_payload", rx_payload_o, 5'h05)
        `CHK("cap_replay_cnt", park_cnt_o, 3'd3)
        `CHK("cap_replay_ready", in_ready_o, 1'b0)
        rx_ready_i = 1'b1;
        #1;
        `CHK("cap_freed_ready", in_ready_o, 1'b1)
        tick();
        in_valid_i = 1'b0;
        `CHK("cap_new_payload", rx_payload_o, 5'h1F)
        tick();
        rx_ready_i = 1'b0;

        // credited replay retried again -> re-parked, err set
        credit_gnt_i = 1'b1; credit_id_i = 3'd2;
        tick();
        credit_gnt_i = 1'b0;
        `CHK("err_clear_before", err_o, 1'b0)
        tick();
        `CHK("rereplay_payload", rx_payload_o, 5'h12)
        `CHK("rereplay_credit", rx_credit_o, 1'b1)
        rx_retry_i = 1'b1;
        tick();
        rx_retry_i = 1'b0;
        `CHK("repark_cnt", park_cnt_o, 3'd3)
        `CHK("repark_err", err_o, 1'b1)

        // asynchronous reset with work in flight
        in_valid_i = 1'b1; in_id_i = 3'd7; in_payload_i = 5'h17;
        tick();
        in_valid_i = 1'b0;
        reset = 1'b1;
        #1;
        `CHK("midrst_valid", rx_valid_o, 1'b0)
        `CHK("midrst_cnt", park_cnt_o, 3'd0)
        `CHK("midrst_err", err_o, 1'b0)
        tick();
        reset = 1'b0;

        // grant with nothing parked -> sticky err
        credit_gnt_i = 1'b1; credit_id_i = 3'd6;
        tick();
        credit_gnt_i = 1'b0;
        `CHK("orphan_gnt_err", err_o, 1'b1)
        repeat (3) tick();
        `CHK("orphan_gnt_sticky", err_o, 1'b1)

        // watchdog: id 4 parked without a grant
`ifdef CREDIT_WDOG_EN
        wdog_exp = 1'b1;
`else
        wdog_exp = 1'b0;
`endif
        in_valid_i = 1'b1; in_id_i = 3'd4; in_payload_i = 5'h04;
        tick();
        in_valid_i = 1'b0; rx_retry_i = 1'b1;
        tick();
        rx_retry_i = 1'b0;
        `CHK("wdog_park_cnt", park_cnt_o, 3'd1)
        repeat (7) tick();
        `CHK("wdog_before_limit", wdog_o, 1'b0)
        tick();
        `CHK("wdog_at_limit", wdog_o, wdog_exp)

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/credit_retry_source.md
Name: credit_retry_source

Overview:
- Upstream issuing agent that feeds the credit/deadlock receiver's RX port: drives rx_valid/id/payload/credit and consumes rx_ready, rx_retry and the credit grant interface.
- A transaction rejected with retry is parked locally until a credit grant with matching id arrives. It is then replayed with rx_credit_o=1.
- Sits between a producer (in_* valid/ready port) and the receiver.

Parameters:
- ID_W, 3, transaction id width
- PL_W, 5, payload width
- NUM_RETRY, 4, parking buffer depth (entries), >=1
- WDOG_CYCLES, 64, parked-without-grant limit, used only with the optional feature

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_valid_i  in  1  producer transaction valid
- in_id_i  in  ID_W  producer id
- in_payload_i  in  PL_W  producer payload
- in_ready_o  out  1  producer accepted when in_valid_i & in_ready_o
- rx_valid_o  out  1  transaction to receiver
- rx_id_o  out  ID_W  id to receiver
- rx_payload_o  out  PL_W  payload to receiver
- rx_credit_o  out  1  1 = credited replay
- rx_ready_i  in  1  receiver accepts
- rx_retry_i  in  1  receiver rejects, retry later
- credit_gnt_i  in  1  credit grant strobe
- credit_id_i  in  ID_W  id of the grant
- park_cnt_o  out  $clog2(NUM_RETRY+1)  parked entries
- err_o  out  1  sticky protocol error
- wdog_o  out  1  watchdog flag (optional feature)

Behaviour:
- Reset: all rx_* outputs 0, park_cnt_o 0, err_o 0, wdog_o 0, buffer empty. in_ready_o is 0 while reset is high and 1 in the first cycle after reset.
- Output stage is a single register holding {id, payload, credit}. rx_* are driven directly from it. Latency from in accept to rx_valid_o is 1 cycle.
- rx_* hold stable while rx_valid_o=1 until done, where done = rx_ready_i | rx_retry_i.
- If rx_ready_i and rx_retry_i are both high, rx_ready_i wins and the transaction is accepted.
- Accept: output stage frees; its contents are dropped.
- Retry: contents {id, payload} are appended to the tail of the parking buffer with granted=0, in the same cycle.
- Parking buffer is an arrival-ordered compacting queue; index 0 is oldest.
- Credit grant: credit_gnt_i marks the oldest entry with id==credit_id_i and granted=0 as granted.
  - No matching entry: the grant is dropped and err_o is set.
  - A grant may match an entry being parked in the same cycle.
- Output stage is free when rx_valid_o=0 or done this cycle. Load priority when free:
  - (1) Oldest granted entry: removed from the buffer and loaded with credit=1.
  - (2) Otherwise, a new producer transaction, loaded with credit=0.
- in_ready_o = free & no granted entry pending & (park_cnt_nxt + 1 <= NUM_RETRY). park_cnt_nxt counts this cycle's park and removal, and the +1 reserves a slot for a possible retry of the new transaction.
- Credited replay retried again: re-parked at the tail with granted=0 and err_o set; no further action.
- Buffer can never overflow by construction. Verification asserts park_cnt_o <= NUM_RETRY.
- Reset mid-operation: parked and in-flight transactions are discarded.

Optional Feature:
- Macro CREDIT_WDOG_EN.
- Defined: a per-entry age counter saturates at WDOG_CYCLES; it increments each cycle the entry is parked and ungranted. Any entry reaching WDOG_CYCLES sets sticky wdog_o, which is cleared only by reset.
- Undefined: no counters are built and wdog_o is tied to 0. The port is always present.

Decomposition:
- Package credit_pkg holds:
  - ID_W and PL_W localparams
  - txn_t struct {id, payload}
  - park_entry_t struct {txn_t txn; granted}
- One sub-module, credit_park_buf, implements:
  - the arrival-ordered queue
  - push, grant-match and pop-oldest-granted
  - count
  - watchdog ages
- The top level owns the output stage, load priority and in_ready.

Test Plan:
- Reset release, then in id=2 payload=0x11 with rx_ready_i=1 -> rx_valid_o on the next cycle with id=2, payload=0x11, credit=0, park_cnt_o=0.
- Issue id=3 with rx_retry_i=1 -> park_cnt_o=1. Then credit_gnt_i id=3 -> next free cycle replays id=3 with credit=1; on rx_ready_i, park_cnt_o=0.
- Park ids 1, 5, 1 in that order, then grant id=1 -> the first id=1 entry (oldest) replays before the new producer data. The second id=1 entry stays parked.
- NUM_RETRY=4 with 3 parked and a new transaction in the output stage -> in_ready_o=0 until a grant or replay frees a slot.
- credit_gnt_i id=6 with nothing parked -> err_o=1, sticky. A credited replay answered with retry -> re-parked and err_o=1.
- With CREDIT_WDOG_EN, WDOG_CYCLES=8: park id=4 with no grant -> wdog_o=1 after 8 cycles. Without the macro, wdog_o stays 0.
